hvsync_decoder: RTL and testbench
=================================

HVSYNC_DECODER -- requirements
Module: hvsync_decoder

Interface
REQ-001 SHALL have parameter H_EDGE_X, default 283, the hpos value in effect on the cycle after an hsync falling edge is detected.
REQ-002 SHALL have parameter V_EDGE_Y, default 256, the vpos value loaded when a vsync falling edge is detected.
REQ-003 SHALL have parameters H_ACTIVE = 256 and V_ACTIVE = 240, the visible width and height.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, the number of consecutive equal periods required to lock.
REQ-005 SHALL have parameter H_MIN_LEN, default 64, the shortest line period accepted as valid.
REQ-006 SHALL have ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- hsync  in  1  active-low horizontal sync.
- vsync  in  1  active-low vertical sync.
- hpos  out  9  recovered horizontal position.
- vpos  out  9  recovered vertical position.
- h_locked  out  1  line timing locked.
- v_locked  out  1  frame timing locked.
- line_len  out  9  measured clocks per line.
- frame_lines  out  9  measured lines per frame.
- display_on  out  1  recovered active area.

Function
REQ-007 SHALL register hsync and vsync once (hs_q, vs_q); a falling edge is hs_q==0 with the previous hs_q==1 (same rule for vsync).
REQ-008 SHALL load hpos with H_EDGE_X at the clock edge that follows hsync edge detection.
REQ-009 In all other cycles, hpos SHALL increment; when h_locked, it wraps to 0 at line_len-1; when unlocked, it saturates at 511.
REQ-010 SHALL increment vpos on each hpos wrap; when v_locked, vpos wraps to 0 at frame_lines-1; when unlocked, it saturates at 511.
REQ-011 A vsync edge SHALL load vpos with V_EDGE_Y; this has priority over the wrap-increment in the same cycle.
REQ-012 SHALL count clocks between successive hsync edges in a 9-bit period counter that saturates at 511.
REQ-013 SHALL run an H-lock FSM with states SEARCH, CHECK and LOCKED; reset enters SEARCH.
REQ-014 SEARCH SHALL move to CHECK on the first hsync edge, clearing the period counter.
REQ-015 In CHECK, on each hsync edge, if period >= H_MIN_LEN and period equals the previous period, the match count SHALL increment; otherwise it SHALL clear.
REQ-016 CHECK SHALL move to LOCKED when the match count reaches LOCK_COUNT-1; line_len latches the period and h_locked rises on that same edge.
REQ-017 In LOCKED, a mismatching period SHALL increment the miss count; two consecutive misses return the FSM to SEARCH and deassert h_locked; a matching period clears the miss count.
REQ-018 In any state, if the period counter saturates at 511, the FSM SHALL enter SEARCH.
REQ-019 SHALL count hsync edges between vsync edges; two consecutive equal counts (while h_locked) SHALL set v_locked and latch frame_lines.
REQ-020 A differing frame count, or loss of h_locked, SHALL clear v_locked.
REQ-021 display_on SHALL be registered, equal to h_locked & v_locked & (hpos < H_ACTIVE) & (vpos < V_ACTIVE) with one cycle of latency.

Reset
REQ-022 Reset SHALL clear hpos, vpos, line_len, frame_lines, h_locked, v_locked, display_on, all counters, and edge history (history resets to 1, i.e. idle-high sync); the FSM enters SEARCH.
REQ-023 Reset asserted mid-lock SHALL drop lock on the next edge; re-lock requires a full LOCK_COUNT sequence.

Configuration
REQ-024 With HVSYNC_DECODER_SYNC_EN defined, a 2-flop synchronizer SHALL precede the edge registers, and the hpos load value SHALL become H_EDGE_X+2 so that positions stay aligned.
REQ-025 Without HVSYNC_DECODER_SYNC_EN, only the single register of REQ-007 SHALL be present.

Structure
REQ-026 A shared package SHALL hold the lock FSM state enum, the 9-bit position type, and the default H/V constants.
REQ-027 The period measure/compare/lock logic SHALL be a sub-module, period_lock, instantiated once for H; V uses the simpler rule in REQ-019.

Verification
REQ-028 Bench SHALL drive the sync generator (300x262 timing, same clk) into the decoder: h_locked SHALL rise within 6 lines and line_len SHALL equal 300.
REQ-029 After v_locked, hpos/vpos SHALL equal the generator's CounterX/CounterY every cycle for 2 frames, with frame_lines = 262.
REQ-030 Holding hsync high for 600 clocks SHALL make h_locked=0 and the FSM return to SEARCH.
REQ-031 A single line of 290 clocks while locked SHALL leave h_locked=1; two consecutive such lines SHALL drop it.
REQ-032 Asserting reset mid-frame SHALL zero all outputs next cycle, and re-lock SHALL follow REQ-028 timing.
REQ-033 With HVSYNC_DECODER_SYNC_EN, the REQ-029 alignment SHALL still hold.

Source files
------------

// File: rtl/hvsync_decoder_pkg.sv
// Shared types and defaults for the hvsync_decoder slice: lock FSM states,
// the 9-bit position type and the default H/V timing constants.
package hvsync_decoder_pkg;

  typedef logic [8:0] pos_t;

  localparam pos_t POS_MAX = 9'd511;

  typedef enum logic [1:0] {
    LOCK_SEARCH = 2'd0,
    LOCK_CHECK  = 2'd1,
    LOCK_LOCKED = 2'd2
  } lock_state_e;

  localparam int H_EDGE_X_DEF   = 283;
  localparam int V_EDGE_Y_DEF   = 256;
  localparam int H_ACTIVE_DEF   = 256;
  localparam int V_ACTIVE_DEF   = 240;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int H_MIN_LEN_DEF  = 64;

  function automatic pos_t sat_inc(input pos_t v);
    return (v == POS_MAX) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/period_lock.sv
// Measures the clock count between sync edges and locks once LOCK_COUNT
// consecutive equal, plausible periods have been seen.
module period_lock
  import hvsync_decoder_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int MIN_LEN    = H_MIN_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_edge,
  output logic       locked,
  output logic [8:0] period_len
);

  localparam logic [1:0] SEARCH = LOCK_SEARCH;
  localparam logic [1:0] CHECK  = LOCK_CHECK;
  localparam logic [1:0] LOCKED = LOCK_LOCKED;

  localparam int              CW         = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]   MATCH_LAST = CW'(LOCK_COUNT - 2);
  localparam pos_t            MIN_PERIOD = pos_t'(MIN_LEN);

  logic [1:0]    state;
  pos_t          period_cnt;
  pos_t          prev_period;
  logic [CW-1:0] match_cnt;
  logic          miss;

  logic period_valid;
  logic period_same;

  assign period_valid = (period_cnt >= MIN_PERIOD);
  assign period_same  = (period_cnt == prev_period);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      period_cnt  <= '0;
      prev_period <= '0;
      match_cnt   <= '0;
      miss        <= 1'b0;
      locked      <= 1'b0;
      period_len  <= '0;
    end else begin
      // The edge cycle itself is the first clock of the next period, so the
      // count seen at the following edge equals the full line length.
      if (sync_edge) begin
        period_cnt  <= 9'd1;
        prev_period <= period_cnt;
      end else begin
        period_cnt <= sat_inc(period_cnt);
      end

      if (period_cnt == POS_MAX) begin
        state     <= SEARCH;
        locked    <= 1'b0;
        match_cnt <= '0;
        miss      <= 1'b0;
      end else if (sync_edge) begin
        case (state)
          SEARCH: begin
            state     <= CHECK;
            match_cnt <= '0;
          end
          CHECK: begin
            if (period_valid && period_same) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MATCH_LAST) begin
                state      <= LOCKED;
                locked     <= 1'b1;
                period_len <= period_cnt;
                miss       <= 1'b0;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (period_cnt == period_len) begin
              miss <= 1'b0;
            end else if (miss) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              miss      <= 1'b0;
              match_cnt <= '0;
            end else begin
              miss <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/hvsync_decoder.sv
// Recovers hpos/vpos, lock status and the active area from raw active-low
// hsync/vsync. Define HVSYNC_DECODER_SYNC_EN to add a 2-flop input synchronizer.
module hvsync_decoder
  import hvsync_decoder_pkg::*;
#(
  parameter int H_EDGE_X   = H_EDGE_X_DEF,
  parameter int V_EDGE_Y   = V_EDGE_Y_DEF,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int H_MIN_LEN  = H_MIN_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       h_locked,
  output logic       v_locked,
  output logic [8:0] line_len,
  output logic [8:0] frame_lines,
  output logic       display_on
);

  logic hs_in;
  logic vs_in;

`ifdef HVSYNC_DECODER_SYNC_EN
  localparam int SYNC_LAT = 2;
  logic [1:0] hs_sync;
  logic [1:0] vs_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync <= 2'b11;
      vs_sync <= 2'b11;
    end else begin
      hs_sync <= {hs_sync[0], hsync};
      vs_sync <= {vs_sync[0], vsync};
    end
  end

  assign hs_in = hs_sync[1];
  assign vs_in = vs_sync[1];
`else
  localparam int SYNC_LAT = 0;
  assign hs_in = hsync;
  assign vs_in = vsync;
`endif

  // The synchronizer delays edge detection, so the load value moves with it.
  localparam pos_t H_LOAD = pos_t'(H_EDGE_X + SYNC_LAT);
  localparam pos_t V_LOAD = pos_t'(V_EDGE_Y);
  localparam pos_t H_VIS  = pos_t'(H_ACTIVE);
  localparam pos_t V_VIS  = pos_t'(V_ACTIVE);

  logic hs_q, hs_prev, vs_q, vs_prev;
  logic hs_fall, vs_fall;

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge values; history resets high to match an idle sync line.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      hs_prev <= 1'b1;
      vs_q    <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      hs_q    <= hs_in;
      hs_prev <= hs_q;
      vs_q    <= vs_in;
      vs_prev <= vs_q;
    end
  end

  assign hs_fall = hs_prev & ~hs_q;
  assign vs_fall = vs_prev & ~vs_q;

  period_lock #(
    .LOCK_COUNT (LOCK_COUNT),
    .MIN_LEN    (H_MIN_LEN)
  ) u_h_lock (
    .clk        (clk),
    .reset      (reset),
    .sync_edge  (hs_fall),
    .locked     (h_locked),
    .period_len (line_len)
  );

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = h_locked && !hs_fall && (hpos >= line_len - 9'd1);
  assign v_wrap = v_locked && (vpos >= frame_lines - 9'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else begin
      if (hs_fall)     hpos <= H_LOAD;
      else if (h_wrap) hpos <= '0;
      else             hpos <= sat_inc(hpos);

      if (vs_fall)     vpos <= V_LOAD;
      else if (h_wrap) vpos <= v_wrap ? '0 : sat_inc(vpos);
    end
  end

  pos_t line_cnt;
  pos_t prev_lines;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt    <= '0;
      prev_lines  <= '0;
      frame_lines <= '0;
      v_locked    <= 1'b0;
    end else begin
      if (vs_fall) begin
        // An hsync edge coinciding with vsync belongs to the new frame.
        line_cnt   <= hs_fall ? 9'd1 : 9'd0;
        prev_lines <= line_cnt;
        if (h_locked && (line_cnt == prev_lines)) begin
          v_locked    <= 1'b1;
          frame_lines <= line_cnt;
        end else begin
          v_locked <= 1'b0;
        end
      end else if (hs_fall) begin
        line_cnt <= sat_inc(line_cnt);
      end
      if (!h_locked) v_locked <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) display_on <= 1'b0;
    else       display_on <= h_locked & v_locked & (hpos < H_VIS) & (vpos < V_VIS);
  end

endmodule

// File: tb/tb_hvsync_decoder.sv
// Drives a 300x262 sync generator into hvsync_decoder and checks lock
// acquisition, position alignment, miss tolerance, sync loss and reset.
module tb_hvsync_decoder;
  import hvsync_decoder_pkg::*;

  localparam int H_TOTAL   = 300;
  localparam int V_TOTAL   = 262;
  localparam int SHORT_LEN = 290;
  // Sync start chosen so that CounterX two clocks after the first low sample
  // equals the decoder's edge constant 283.
  localparam int HS_START  = 281;
  localparam int HS_WIDTH  = 16;
  localparam int VS_START  = 256;
  localparam int VS_LINES  = 3;
  localparam int H_VIS     = 256;
  localparam int V_VIS     = 240;
  localparam int PROBE_X   = HS_START + 6;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       h_locked;
  logic       v_locked;
  logic [8:0] line_len;
  logic [8:0] frame_lines;
  logic       display_on;

  int checks;
  int errors;

  int cx, cy, cur_len, prev_cx, prev_cy, short_pending;
  bit hold_hs;
  bit found;

  hvsync_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .hpos        (hpos),
    .vpos        (vpos),
    .h_locked    (h_locked),
    .v_locked    (v_locked),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .display_on  (display_on)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(10 * 1_000_000);
    $display("FAIL watchdog cycle budget exhausted checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation did not terminate");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_sync();
    hsync = (hold_hs || !(cx >= HS_START && cx < HS_START + HS_WIDTH)) ? 1'b1 : 1'b0;
    vsync = (cy >= VS_START && cy < VS_START + VS_LINES) ? 1'b0 : 1'b1;
  endtask

  // Ideal generator: CounterX/CounterY advance right after each clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
    prev_cx = cx;
    prev_cy = cy;
    cx++;
    if (cx >= cur_len) begin
      cx = 0;
      cy = (cy == V_TOTAL - 1) ? 0 : cy + 1;
      if (short_pending > 0) begin
        cur_len = SHORT_LEN;
        short_pending--;
      end else begin
        cur_len = H_TOTAL;
      end
    end
    drive_sync();
  endtask

  // Run through n line starts, then to just after the next hsync edge has
  // been absorbed by the decoder.
  task automatic advance_lines(input int n);
    int wraps;
    wraps = 0;
    for (int i = 0; i < (n + 1) * H_TOTAL + 10; i++) begin
      tick();
      if (cx == 0) wraps++;
      if (wraps >= n && cx == PROBE_X) break;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hpos"}, hpos, 0);
    check({tag, "_vpos"}, vpos, 0);
    check({tag, "_h_locked"}, h_locked, 0);
    check({tag, "_v_locked"}, v_locked, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_display_on"}, display_on, 0);
  endtask

  task automatic wait_h_lock(input string tag);
    found = 0;
    for (int i = 0; i < 6 * H_TOTAL; i++) begin
      tick();
      if (h_locked === 1'b1) begin
        found = 1;
        break;
      end
    end
    check({tag, "_h_locked"}, found, 1);
    check({tag, "_line_len"}, line_len, H_TOTAL);
  endtask

  initial begin
    int bad;
    int de_cnt;
    bit exp_de;

    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    hold_hs       = 1'b0;
    short_pending = 0;
    cur_len       = H_TOTAL;
    cx            = $urandom_range(0, H_TOTAL - 1);
    cy            = $urandom_range(250, 254);
    prev_cx       = cx;
    prev_cy       = cy;
    drive_sync();

    repeat (5) tick();
    check_zero("por");
    reset = 1'b0;

    wait_h_lock("acquire");

    found = 0;
    for (int i = 0; i < 4 * V_TOTAL * H_TOTAL; i++) begin
      tick();
      if (v_locked === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("v_lock_acquire", found, 1);
    check("frame_lines", frame_lines, V_TOTAL);

    for (int f = 0; f < 2; f++) begin
      bad    = 0;
      de_cnt = 0;
      for (int i = 0; i < V_TOTAL * H_TOTAL; i++) begin
        tick();
        exp_de = (prev_cx < H_VIS) && (prev_cy < V_VIS);
        if (display_on === 1'b1) de_cnt++;
        if (hpos !== 9'(cx) || vpos !== 9'(cy) || display_on !== exp_de ||
            h_locked !== 1'b1 || v_locked !== 1'b1) bad++;
      end
      check($sformatf("align_frame%0d_bad_cycles", f), bad, 0);
      check($sformatf("display_frame%0d_count", f), de_cnt, H_VIS * V_VIS);
    end

    advance_lines($urandom_range(1, 3));
    short_pending = 1;
    advance_lines(2);
    check("short_one_h_locked", h_locked, 1);
    check("short_one_line_len", line_len, H_TOTAL);
    advance_lines(1);

    short_pending = 2;
    advance_lines(2);
    check("short_pair_first_h_locked", h_locked, 1);
    advance_lines(1);
    check("short_pair_h_dropped", h_locked, 0);
    check("short_pair_v_dropped", v_locked, 0);

    wait_h_lock("relock_short");

    repeat ($urandom_range(0, H_TOTAL - 1)) tick();
    hold_hs = 1'b1;
    repeat (600) tick();
    check("hold_h_locked", h_locked, 0);
    check("hold_v_locked", v_locked, 0);
    check("hold_state", dut.u_h_lock.state, LOCK_SEARCH);
    hold_hs = 1'b0;

    wait_h_lock("relock_hold");
    repeat ($urandom_range(1000, 30000)) tick();
    reset = 1'b1;
    tick();
    check_zero("mid_reset");
    reset = 1'b0;
    wait_h_lock("relock_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
